tex_rom_arbiter: RTL and testbench

- Shares one single-port texture BROM between `NUM_REQ` texture requesters (the parallel transformation lanes) so that several column flatteners can texture walls at once.
- Grants at most one request per cycle.
- Turns each request into a texture ROM address and returns the fetched texel to the originating requester after a fixed latency.
- Sits between the transformation lanes and the texture ROM; there is no response backpressure.

---
 rtl/tex_rom_arbiter.sv | 119 +++++++++++
 tb/tb_tex_rom_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tex_rom_arbiter.sv
// Shares one single-port texture ROM between NUM_REQ requesters and returns each texel to its requester.
// Build option: define TEX_ARB_RR_EN for round-robin arbitration; without it the lowest index wins.
module tex_rom_arbiter #(
  parameter int          NUM_REQ     = 2,
  parameter int          ROM_LATENCY = 2,
  parameter logic [15:0] ERROR_COLOR = 16'hF81F
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  input  logic [NUM_REQ-1:0]     req_valid_in,
  input  logic [4*NUM_REQ-1:0]   req_texture_in,
  input  logic [16*NUM_REQ-1:0]  req_wallx_in,
  input  logic [6*NUM_REQ-1:0]   req_texy_in,
  output logic [NUM_REQ-1:0]     req_ready_out,
  output logic [NUM_REQ-1:0]     rsp_valid_out,
  output logic [15:0]            rsp_pixel_out,
  output logic [13:0]            rom_addr_out,
  input  logic [15:0]            rom_data_in,
  output logic                   busy_out
);

  localparam int ID_W  = (NUM_REQ > 2) ? 2 : 1;
  localparam int DEPTH = ROM_LATENCY + 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]      state;
  logic            grant_any;
  logic [ID_W-1:0] grant_id;
  logic            transfer;

  logic [3:0]      tex_sel;
  logic [3:0]      tex_off;
  logic [5:0]      texy_sel;
  logic [15:0]     wallx_sel;
  logic            tex_err;

  logic [DEPTH-1:0] pipe_valid;
  logic [DEPTH-1:0] pipe_err;
  logic [ID_W-1:0]  pipe_id [DEPTH];

`ifdef TEX_ARB_RR_EN
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] cand;

  // Search begins one past the previous winner and wraps, so every valid requester is reached.
  always_comb begin
    // NOTE: every comb output gets a default before the loop, so no path can infer a latch.
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_any && req_valid_in[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end
`else
  always_comb begin
    grant_any = |req_valid_in;
    grant_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_in[k]) grant_id = ID_W'(k);
    end
  end
`endif

  assign req_ready_out = (grant_any && !rst_in) ? (ONE_HOT0 << grant_id) : '0;
  assign transfer      = |req_ready_out;

  assign tex_sel   = req_texture_in[4*grant_id +: 4];
  assign texy_sel  = req_texy_in[6*grant_id +: 6];
  assign wallx_sel = req_wallx_in[16*grant_id +: 16];
  assign tex_off   = tex_sel - 4'd3;
  assign tex_err   = (tex_sel < 4'd3) || (tex_sel > 4'd5);

  always_ff @(posedge pixel_clk_in) begin
    // NOTE: the tag pipeline is reset too, so a mid-flight reset drops responses; all state uses <=.
    if (rst_in) begin
      pipe_valid    <= '0;
      pipe_err      <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_id[i] <= '0;
      rom_addr_out  <= '0;
      rsp_valid_out <= '0;
      rsp_pixel_out <= '0;
      state         <= ST_IDLE;
`ifdef TEX_ARB_RR_EN
      last_grant    <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      pipe_valid <= {pipe_valid[DEPTH-2:0], transfer};
      pipe_err   <= {pipe_err[DEPTH-2:0], transfer & tex_err};
      pipe_id[0] <= grant_id;
      for (int i = 1; i < DEPTH; i++) pipe_id[i] <= pipe_id[i-1];

      if (transfer) begin
        rom_addr_out <= tex_err ? 14'd0 : {tex_off[1:0], texy_sel, wallx_sel[15:10]};
`ifdef TEX_ARB_RR_EN
        last_grant   <= grant_id;
`endif
      end

      rsp_valid_out <= pipe_valid[DEPTH-1] ? (ONE_HOT0 << pipe_id[DEPTH-1]) : '0;
      if (pipe_valid[DEPTH-1]) begin
        rsp_pixel_out <= pipe_err[DEPTH-1] ? ERROR_COLOR : rom_data_in;
      end

      // Stay active while any tag or the response register will hold a valid entry next cycle.
      state <= (transfer || |pipe_valid) ? ST_ACTIVE : ST_IDLE;
    end
  end

  assign busy_out = (state == ST_ACTIVE);

endmodule

// File: tb/tb_tex_rom_arbiter.sv
// Self-checking bench for tex_rom_arbiter: table vectors plus burst, drain and mid-flight reset sequences.
// Arbitration expectations follow TEX_ARB_RR_EN the same way the design does.
module tb_tex_rom_arbiter;

  localparam int N = 2;

  logic          pixel_clk_in = 1'b0;
  logic          rst_in;
  logic [N-1:0]  req_valid_in;
  logic [4*N-1:0]  req_texture_in;
  logic [16*N-1:0] req_wallx_in;
  logic [6*N-1:0]  req_texy_in;
  logic [N-1:0]  req_ready_out;
  logic [N-1:0]  rsp_valid_out;
  logic [15:0]   rsp_pixel_out;
  logic [13:0]   rom_addr_out;
  logic [15:0]   rom_data_in;
  logic          busy_out;
  logic [15:0]   rom_d1;

  always #5 pixel_clk_in = ~pixel_clk_in;

  tex_rom_arbiter #(.NUM_REQ(N), .ROM_LATENCY(2), .ERROR_COLOR(16'hF81F)) dut (
    .pixel_clk_in   (pixel_clk_in),
    .rst_in         (rst_in),
    .req_valid_in   (req_valid_in),
    .req_texture_in (req_texture_in),
    .req_wallx_in   (req_wallx_in),
    .req_texy_in    (req_texy_in),
    .req_ready_out  (req_ready_out),
    .rsp_valid_out  (rsp_valid_out),
    .rsp_pixel_out  (rsp_pixel_out),
    .rom_addr_out   (rom_addr_out),
    .rom_data_in    (rom_data_in),
    .busy_out       (busy_out)
  );

  function automatic logic [15:0] rom_word(input logic [13:0] a);
    return {a[5:0], a[13:4]} ^ 16'h5A3C;
  endfunction

  // Two-cycle ROM: data for an address appears two edges after the address changes.
  always_ff @(posedge pixel_clk_in) begin
    rom_d1      <= rom_word(rom_addr_out);
    rom_data_in <= rom_d1;
  end

  typedef struct {
    logic [1:0]  valid;
    logic [3:0]  tex0, tex1;
    logic [15:0] wx0, wx1;
    logic [5:0]  ty0, ty1;
    logic [1:0]  rr_grant, fp_grant;
  } vec_t;

  typedef struct {
    int          due;
    int          id;
    logic [15:0] pixel;
  } rsp_t;

  rsp_t        sb[$];
  int          lg = N - 1;
  logic [13:0] exp_addr = '0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] model_grant(input logic [1:0] v);
    if (v == 2'b00) return 2'b00;
`ifdef TEX_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (lg + k) % N;
      if (v[idx]) return 2'b01 << idx;
    end
    return 2'b00;
`else
    return v[0] ? 2'b01 : 2'b10;
`endif
  endfunction

  // Drive one cycle of inputs, check outputs at the falling edge, then advance the model across the rising edge.
  task automatic step(input logic r, input logic [1:0] v, input logic [7:0] tex,
                      input logic [31:0] wx, input logic [11:0] ty, output logic [1:0] act_ready);
    logic [1:0]  g;
    logic [1:0]  oh;
    logic [3:0]  t;
    logic [3:0]  toff;
    logic        err;
    int          id;
    rsp_t        e;
    rst_in = r; req_valid_in = v; req_texture_in = tex; req_wallx_in = wx; req_texy_in = ty;
    @(negedge pixel_clk_in);
    act_ready = req_ready_out;
    g = r ? 2'b00 : model_grant(v);
    check("ready", req_ready_out, g);
    check("rom_addr", rom_addr_out, exp_addr);
    check("busy", busy_out, sb.size() != 0);
    if (sb.size() != 0 && sb[0].due == cyc) begin
      oh = 2'b01 << sb[0].id;
      check("rsp_valid", rsp_valid_out, oh);
      check("rsp_pixel", rsp_pixel_out, sb[0].pixel);
      void'(sb.pop_front());
    end else begin
      check("rsp_idle", rsp_valid_out, 2'b00);
    end
    if (r) begin
      sb.delete();
      lg = N - 1;
      exp_addr = '0;
    end else if (g != 2'b00) begin
      id   = g[1] ? 1 : 0;
      t    = tex[id*4 +: 4];
      err  = (t < 4'd3) || (t > 4'd5);
      toff = t - 4'd3;
      exp_addr = err ? 14'd0 : {toff[1:0], ty[id*6 +: 6], wx[id*16+10 +: 6]};
      e.due   = cyc + 4;
      e.id    = id;
      e.pixel = err ? 16'hF81F : rom_word(exp_addr);
      sb.push_back(e);
      lg = id;
    end
    @(posedge pixel_clk_in);
    cyc++;
    #1;
  endtask

  vec_t        tv[8];
  logic [1:0]  act;
  int          cnt0, cnt1;

  initial begin
    tv[0] = '{2'b01, 4'd4, 4'd0, 16'hFC00, 16'h0000, 6'd5, 6'd0,  2'b01, 2'b01};
    tv[1] = '{2'b00, 4'd4, 4'd0, 16'hFC00, 16'h0000, 6'd5, 6'd0,  2'b00, 2'b00};
    tv[2] = '{2'b10, 4'd4, 4'd7, 16'hFC00, 16'h1234, 6'd5, 6'd9,  2'b10, 2'b10};
    tv[3] = '{2'b10, 4'd4, 4'd3, 16'hFC00, 16'h0400, 6'd5, 6'd63, 2'b10, 2'b10};
    tv[4] = '{2'b11, 4'd5, 4'd5, 16'h8000, 16'h7C00, 6'd1, 6'd2,  2'b01, 2'b01};
    tv[5] = '{2'b11, 4'd5, 4'd5, 16'h8000, 16'h7C00, 6'd1, 6'd2,  2'b10, 2'b01};
    tv[6] = '{2'b11, 4'd5, 4'd5, 16'h8000, 16'h7C00, 6'd1, 6'd2,  2'b01, 2'b01};
    tv[7] = '{2'b01, 4'd0, 4'd5, 16'hFFFF, 16'h7C00, 6'd0, 6'd2,  2'b01, 2'b01};

    rst_in = 1'b1; req_valid_in = '0; req_texture_in = '0; req_wallx_in = '0; req_texy_in = '0;
    repeat (2) @(posedge pixel_clk_in);
    #1;
    check("reset_pixel", rsp_pixel_out, 16'h0000);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, tv[i].valid, {tv[i].tex1, tv[i].tex0}, {tv[i].wx1, tv[i].wx0},
           {tv[i].ty1, tv[i].ty0}, act);
`ifdef TEX_ARB_RR_EN
      check("tbl_grant", act, tv[i].rr_grant);
`else
      check("tbl_grant", act, tv[i].fp_grant);
`endif
      if (i == 0) check("addr_117f", rom_addr_out, 14'h117F);
      if (i == 2) check("addr_err0", rom_addr_out, 14'h0000);
    end

    // Both requesters valid for eight cycles.
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'b11, {4'd3, 4'd4}, {16'hA400, 16'h3800}, {6'd17, 6'd40}, act);
      if (act[0]) cnt0++;
      if (act[1]) cnt1++;
    end
`ifdef TEX_ARB_RR_EN
    check("burst_cnt0", cnt0, 4);
    check("burst_cnt1", cnt1, 4);
`else
    check("burst_cnt0", cnt0, 8);
    check("burst_cnt1", cnt1, 0);
`endif

    // Drain: busy must fall right after the final response cycle.
    for (int i = 0; i < 6; i++) step(1'b0, 2'b00, '0, '0, '0, act);
    check("drained_busy", busy_out, 1'b0);

    // Mid-flight reset drops outstanding responses and restores requester 0 priority.
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, {4'd0, 4'd5}, {16'h0000, 16'h4C00 + 16'(i*1024)}, {6'd0, 6'(i)}, act);
    step(1'b0, 2'b00, '0, '0, '0, act);
    step(1'b1, 2'b00, '0, '0, '0, act);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00, '0, '0, '0, act);
    check("post_rst_busy", busy_out, 1'b0);
    step(1'b0, 2'b11, {4'd4, 4'd3}, {16'h0800, 16'hF000}, {6'd3, 6'd60}, act);
    check("post_rst_grant", act, 2'b01);
    for (int i = 0; i < 6; i++) step(1'b0, 2'b00, '0, '0, '0, act);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
